even_issue_sched: RTL and testbench
===================================

Name: even_issue_sched

Overview:
- Issue scheduler in front of EvenPipe (FP, FX2, Byte, FX1 units).
- Accepts one decoded even-pipe instruction per cycle and holds it until two hazards clear:
  - RAW: a source register is still in flight.
  - Writeback-port collision: a shorter-latency op would reach WB in the same cycle as an older op.
- Tracks in-flight destinations in a latency-indexed scoreboard and supports drain and flush.

Parameters:
- LAT_FP, 6, issue-to-WB cycles for unit 0 (FP).
- LAT_FX2, 4, issue-to-WB cycles for unit 1 (FX2).
- LAT_BYTE, 4, issue-to-WB cycles for unit 2 (Byte).
- LAT_FX1, 2, issue-to-WB cycles for unit 3 (FX1).
- MAX_LAT, 7, scoreboard depth; must be at least the largest LAT_*.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  scheduler accepts instruction this cycle.
- in_unit  in  2  execution unit (0 FP, 1 FX2, 2 Byte, 3 FX1).
- in_rt_addr  in  7  destination register [0:6].
- in_reg_write  in  1  instruction writes RT.
- in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  source registers [0:6].
- in_src_use  in  3  {ra, rb, rc} source-valid flags.
- issue  out  1  registered; instruction enters EvenPipe RF stage.
- issue_unit  out  2  registered copy of accepted in_unit.
- flush  in  1  kill all in-flight scoreboard entries.
- drain_req  in  1  stop accepting until pipe empty.
- drained  out  1  drain complete, scoreboard empty.
- sb_busy  out  1  any scoreboard slot valid.

Behaviour:
- Scoreboard:
  - MAX_LAT slots; each holds {valid, rt_addr, reg_write}.
  - Every cycle slot[k] <= slot[k+1]; slot[MAX_LAT-1] <= empty.
  - Issue with latency L writes slot[L-1] in the same edge, overriding the shifted value.
  - Slot 0 valid means that op is in WB this cycle.
- RAW stall: any used source equals rt_addr of a valid slot with reg_write=1, slot 0 included (no forwarding from WB).
  - Source address 0 is not special.
- WB stall: slot[L] is valid (it would land in slot[L-1] at the same time as the new op).
  - L = MAX_LAT has no collision check.
- in_ready = state==RUN && !RAW && !WB && !flush.
  - Acceptance = in_valid && in_ready.
  - An instruction with in_reg_write=0 still reserves its WB slot.
- issue / issue_unit register acceptance; 1-cycle latency from handshake.
- FSM states RUN, STALL, DRAIN:
  - RUN -> STALL: in_valid && hazard.
  - STALL -> RUN: hazard clear. Accept in the same cycle; no bubble beyond the hazard.
  - any -> DRAIN: drain_req=1.
  - DRAIN: in_ready=0. drained=1 when all slots empty; stays 1 while drain_req held.
  - DRAIN -> RUN: drain_req=0.
  - drain_req has priority over STALL.
- flush:
  - Clears all slot valid bits at the edge; in_ready=0 during the flush cycle.
  - The held input is not lost; the upstream stage keeps in_valid.
  - flush together with an issue: the issue is dropped and issue=0 next cycle.
- Simultaneous retire and issue of the same rt: legal; the new entry is written while the old one retires.
- Reset (async, mid-operation allowed): all slots invalid, state=RUN, issue=0, issue_unit=0, drained=0, sb_busy=0.
- in_ready is combinational from registered state plus inputs; no combinational path from issue.

Optional Feature:
- Macro EVEN_SCHED_PERF_EN.
- Defined: adds outputs raw_stall_cnt[31:0], wb_stall_cnt[31:0], issue_cnt[31:0].
  - Each counts cycles with in_valid && the respective stall, or accepted instructions.
  - RAW has precedence when both stalls apply.
  - Counters saturate at all-ones and clear on reset only.
- Undefined: counters and ports absent; behaviour otherwise identical.

Test Plan:
- Reset held low 2 cycles, then release; steady in_valid FX1 ops with distinct rt/sources -> in_ready=1 every cycle; issue pulses 1 cycle after each handshake; issue_unit=3.
- FP op rt=3, next FX1 op with ra=3 -> in_ready=0 for 6 cycles; accepted on cycle 7 after the FP issue, once slot 0 is cleared.
- FP op issued at cycle t; FX2 at t+1 (hits WB t+5 vs FP t+6: OK) -> accepted. FX1 op at t+4 (WB t+6 collides) -> stalled exactly 1 cycle.
- drain_req asserted with 3 ops in flight (max latency 6) -> in_ready=0; drained=1 once sb_busy=0 (≤6 cycles); drain_req low -> RUN, next op accepted.
- flush while RAW-stalled on rt=5 -> next cycle slots empty, stalled op accepted, sb_busy then reflects only the new op.
- reset pulled low mid-stall with sb_busy=1 -> sb_busy=0, issue=0 immediately (async). With EVEN_SCHED_PERF_EN: counters read 0.

Source files
------------

// File: rtl/even_issue_sched_if.sv
// Decoded-instruction handshake from the even-pipe decode stage into even_issue_sched.
// master = upstream decode stage, slave = scheduler.
interface even_issue_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_unit;
  logic [6:0] in_rt_addr;
  logic       in_reg_write;
  logic [6:0] in_ra_addr;
  logic [6:0] in_rb_addr;
  logic [6:0] in_rc_addr;
  logic [2:0] in_src_use;

  modport master (
    output in_valid, in_unit, in_rt_addr, in_reg_write,
           in_ra_addr, in_rb_addr, in_rc_addr, in_src_use,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_unit, in_rt_addr, in_reg_write,
           in_ra_addr, in_rb_addr, in_rc_addr, in_src_use,
    output in_ready
  );
endinterface

// File: rtl/even_issue_sched.sv
// Even-pipe issue scheduler: holds one decoded op until RAW and WB-port hazards clear.
// Define EVEN_SCHED_PERF_EN to add saturating stall/issue performance counters.
module even_issue_sched #(
  parameter int LAT_FP   = 6,
  parameter int LAT_FX2  = 4,
  parameter int LAT_BYTE = 4,
  parameter int LAT_FX1  = 2,
  parameter int MAX_LAT  = 7
) (
  input  logic               clk,
  input  logic               reset,
  even_issue_sched_if.slave  in_if,
  input  logic               flush,
  input  logic               drain_req,
  output logic               issue,
  output logic [1:0]         issue_unit,
  output logic               drained,
  output logic               sb_busy
`ifdef EVEN_SCHED_PERF_EN
  ,
  output logic [31:0]        raw_stall_cnt,
  output logic [31:0]        wb_stall_cnt,
  output logic [31:0]        issue_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_DRAIN} state_e;

  typedef struct packed {
    logic       valid;
    logic [6:0] rt_addr;
    logic       reg_write;
  } slot_t;

  state_e              state_q, state_d;
  slot_t [MAX_LAT-1:0] sb_q, sb_d;
  logic                issue_q, issue_d;
  logic [1:0]          issue_unit_q, issue_unit_d;

  int   lat;
  logic raw_hit;
  logic wb_hit;
  logic hazard;
  logic accept;

  function automatic int unit_lat(input logic [1:0] unit);
    case (unit)
      2'd0:    return LAT_FP;
      2'd1:    return LAT_FX2;
      2'd2:    return LAT_BYTE;
      default: return LAT_FX1;
    endcase
  endfunction

  // Slot k holds the op that reaches WB k cycles from now; slot 0 is in WB this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lat     = unit_lat(in_if.in_unit);
    raw_hit = 1'b0;
    wb_hit  = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (sb_q[k].valid && sb_q[k].reg_write &&
          ((in_if.in_src_use[2] && (in_if.in_ra_addr == sb_q[k].rt_addr)) ||
           (in_if.in_src_use[1] && (in_if.in_rb_addr == sb_q[k].rt_addr)) ||
           (in_if.in_src_use[0] && (in_if.in_rc_addr == sb_q[k].rt_addr))))
        raw_hit = 1'b1;
      // An op in slot[lat] would shift into slot[lat-1] on the same edge as the new op.
      if (sb_q[k].valid && (k == lat))
        wb_hit = 1'b1;
    end
  end

  assign hazard = raw_hit | wb_hit;

  // drain_req gates acceptance immediately, before the FSM has reached DRAIN.
  assign in_if.in_ready = (state_q != ST_DRAIN) && !drain_req && !hazard && !flush;
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++)
      sb_d[k] = sb_q[k+1];
    sb_d[MAX_LAT-1] = '0;
    if (accept) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (k == lat - 1) begin
          sb_d[k].valid     = 1'b1;
          sb_d[k].rt_addr   = in_if.in_rt_addr;
          sb_d[k].reg_write = in_if.in_reg_write;
        end
      end
    end
    if (flush)
      sb_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (drain_req) begin
      state_d = ST_DRAIN;
    end else begin
      case (state_q)
        ST_RUN:   if (in_if.in_valid && hazard) state_d = ST_STALL;
        ST_STALL: if (!hazard) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  assign issue_d      = accept;
  assign issue_unit_d = accept ? in_if.in_unit : issue_unit_q;

  always_comb begin
    sb_busy = 1'b0;
    for (int k = 0; k < MAX_LAT; k++)
      sb_busy = sb_busy | sb_q[k].valid;
  end

  assign drained    = (state_q == ST_DRAIN) && !sb_busy;
  assign issue      = issue_q;
  assign issue_unit = issue_unit_q;

  // NOTE: the scoreboard is flop-based and must be reset; a stale valid slot would stall forever.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      sb_q         <= '0;
      issue_q      <= 1'b0;
      issue_unit_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      sb_q         <= sb_d;
      issue_q      <= issue_d;
      issue_unit_q <= issue_unit_d;
    end
  end

`ifdef EVEN_SCHED_PERF_EN
  logic [31:0] raw_cnt_q, raw_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;
  logic [31:0] iss_cnt_q, iss_cnt_d;

  // RAW takes precedence when both hazards apply; all counters saturate.
  always_comb begin
    raw_cnt_d = raw_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    iss_cnt_d = iss_cnt_q;
    if (in_if.in_valid && raw_hit && (raw_cnt_q != '1))
      raw_cnt_d = raw_cnt_q + 32'd1;
    if (in_if.in_valid && !raw_hit && wb_hit && (wb_cnt_q != '1))
      wb_cnt_d = wb_cnt_q + 32'd1;
    if (accept && (iss_cnt_q != '1))
      iss_cnt_d = iss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_cnt_q <= '0;
      wb_cnt_q  <= '0;
      iss_cnt_q <= '0;
    end else begin
      raw_cnt_q <= raw_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
      iss_cnt_q <= iss_cnt_d;
    end
  end

  assign raw_stall_cnt = raw_cnt_q;
  assign wb_stall_cnt  = wb_cnt_q;
  assign issue_cnt     = iss_cnt_q;
`endif

endmodule

// File: tb/tb_even_issue_sched.sv
// Self-checking bench for even_issue_sched: directed scenarios plus random traffic,
// checked against an in-flight op list keyed by absolute writeback cycle.
module tb_even_issue_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       flush;
  logic       drain_req;
  logic       issue;
  logic [1:0] issue_unit;
  logic       drained;
  logic       sb_busy;
`ifdef EVEN_SCHED_PERF_EN
  logic [31:0] raw_stall_cnt, wb_stall_cnt, issue_cnt;
`endif

  even_issue_sched_if bus();

  even_issue_sched dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
    .flush      (flush),
    .drain_req  (drain_req),
    .issue      (issue),
    .issue_unit (issue_unit),
    .drained    (drained),
    .sb_busy    (sb_busy)
`ifdef EVEN_SCHED_PERF_EN
    ,
    .raw_stall_cnt (raw_stall_cnt),
    .wb_stall_cnt  (wb_stall_cnt),
    .issue_cnt     (issue_cnt)
`endif
  );

  // Reference model: each in-flight op is remembered with the absolute cycle it reaches WB.
  typedef struct {
    int rt;
    bit rw;
    int wb;
  } op_t;

  op_t q[$];
  int  cyc;
  bit  m_drain;
  bit  m_issue;
  int  m_unit;
  int  m_raw, m_wbs, m_iss;
  bit  dut_acc;
  bit  last_drained;
  int  n_checks;
  int  n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int unit);
    case (unit)
      0:       return 6;
      1:       return 4;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_drain = 1'b0;
    m_issue = 1'b0;
    m_unit  = 0;
    m_raw   = 0;
    m_wbs   = 0;
    m_iss   = 0;
  endtask

  task automatic drive(input bit v, input int unit, input int rt, input bit rw,
                       input int ra, input int rb, input int rc, input int use_);
    bus.in_valid     = v;
    bus.in_unit      = 2'(unit);
    bus.in_rt_addr   = 7'(rt);
    bus.in_reg_write = rw;
    bus.in_ra_addr   = 7'(ra);
    bus.in_rb_addr   = 7'(rb);
    bus.in_rc_addr   = 7'(rc);
    bus.in_src_use   = 3'(use_);
  endtask

  // One clock: entered at a negedge with inputs already driven, returns at the next negedge.
  task automatic cycle();
    op_t keep[$];
    bit  raw, wbh, er, acc;
    int  lat;
    #1;
    foreach (q[i]) if (q[i].wb >= cyc) keep.push_back(q[i]);
    q   = keep;
    lat = lat_of(int'(bus.in_unit));
    raw = 1'b0;
    wbh = 1'b0;
    foreach (q[i]) begin
      if (q[i].rw && ((bus.in_src_use[2] && int'(bus.in_ra_addr) == q[i].rt) ||
                      (bus.in_src_use[1] && int'(bus.in_rb_addr) == q[i].rt) ||
                      (bus.in_src_use[0] && int'(bus.in_rc_addr) == q[i].rt)))
        raw = 1'b1;
      if (q[i].wb == cyc + lat) wbh = 1'b1;
    end
    er = !m_drain && !drain_req && !flush && !raw && !wbh;
    check("in_ready", bus.in_ready, er);
    check("sb_busy", sb_busy, q.size() != 0);
    check("drained", drained, m_drain && (q.size() == 0));
    check("issue", issue, m_issue);
    if (m_issue) check("issue_unit", issue_unit, m_unit);
`ifdef EVEN_SCHED_PERF_EN
    check("raw_stall_cnt", raw_stall_cnt, m_raw);
    check("wb_stall_cnt", wb_stall_cnt, m_wbs);
    check("issue_cnt", issue_cnt, m_iss);
`endif
    dut_acc      = bus.in_valid && bus.in_ready;
    last_drained = drained;
    acc          = bus.in_valid && er;
    @(posedge clk);
    if (flush) q.delete();
    if (acc) q.push_back('{rt: int'(bus.in_rt_addr), rw: bus.in_reg_write, wb: cyc + lat});
    if (bus.in_valid && raw) m_raw++;
    else if (bus.in_valid && wbh) m_wbs++;
    if (acc) begin
      m_iss++;
      m_unit = int'(bus.in_unit);
    end
    m_issue = acc;
    m_drain = drain_req;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3, 0, 1'b0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  // Offers one op and holds it until the DUT takes it; waits = cycles spent stalled.
  task automatic send(input int unit, input int rt, input bit rw, input int ra, input int rb,
                      input int rc, input int use_, output int waits);
    bit done;
    drive(1'b1, unit, rt, rw, ra, rb, rc, use_);
    waits = 0;
    done  = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      cycle();
      if (dut_acc) done = 1'b1;
      else waits++;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    drive(1'b0, 3, 0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    bit have;
    int p_unit, p_rt, p_ra, p_rb, p_rc, p_use;
    bit p_rw;
    int drain_cnt;

    n_checks  = 0;
    n_bad     = 0;
    cyc       = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    drain_req = 1'b0;
    drive(1'b0, 3, 0, 1'b0, 0, 0, 0, 0);
    model_reset();

    // Reset held for two cycles.
    @(negedge clk);
    check("rst_issue", issue, 1'b0);
    check("rst_issue_unit", issue_unit, 2'd0);
    check("rst_drained", drained, 1'b0);
    check("rst_sb_busy", sb_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back independent FX1 ops flow with no stalls.
    for (int i = 0; i < 8; i++) begin
      send(3, 10 + i, 1'b1, 40 + i, 50 + i, 60 + i, 3'b111, w);
      check("fx1_stream_wait", w, 0);
    end
    idle(2);

    // RAW on an FP result: consumer waits until the producer has left WB.
    idle(8);
    send(0, 3, 1'b1, 20, 21, 22, 3'b000, w);
    send(3, 30, 1'b1, 3, 23, 24, 3'b100, w);
    check("raw_fp_wait", w, 6);

    // WB-port collision: FX2 right after FP is fine, FX1 four cycles later loses one cycle.
    idle(8);
    send(0, 31, 1'b1, 0, 0, 0, 3'b000, w);
    check("wb_fp_wait", w, 0);
    send(1, 32, 1'b1, 0, 0, 0, 3'b000, w);
    check("wb_fx2_wait", w, 0);
    idle(2);
    send(3, 33, 1'b1, 0, 0, 0, 3'b000, w);
    check("wb_fx1_wait", w, 1);

    // Drain with three ops in flight, then resume.
    idle(8);
    send(0, 40, 1'b1, 0, 0, 0, 3'b000, w);
    send(1, 41, 1'b1, 0, 0, 0, 3'b000, w);
    send(3, 42, 1'b1, 0, 0, 0, 3'b000, w);
    drive(1'b1, 3, 43, 1'b1, 0, 0, 0, 3'b000);
    drain_req    = 1'b1;
    n            = 0;
    last_drained = 1'b0;
    while (!last_drained && n < 12) begin
      cycle();
      n++;
    end
    check("drain_reached", last_drained, 1'b1);
    check("drain_in_time", (n <= 6) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) cycle();
    drain_req = 1'b0;
    send(3, 43, 1'b1, 0, 0, 0, 3'b000, w);
    check("drain_resume_wait", w, 1);

    // Flush while RAW-stalled on rt=5: the held op goes right after the flush.
    idle(8);
    send(0, 5, 1'b1, 0, 0, 0, 3'b000, w);
    drive(1'b1, 3, 35, 1'b1, 5, 0, 0, 3'b100);
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    send(3, 35, 1'b1, 5, 0, 0, 3'b100, w);
    check("flush_release_wait", w, 0);
    idle(3);

    // Asynchronous reset mid-stall.
    idle(8);
    send(0, 5, 1'b1, 0, 0, 0, 3'b000, w);
    drive(1'b1, 3, 36, 1'b1, 5, 0, 0, 3'b100);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_issue", issue, 1'b0);
    check("async_rst_sb_busy", sb_busy, 1'b0);
    check("async_rst_issue_unit", issue_unit, 2'd0);
`ifdef EVEN_SCHED_PERF_EN
    check("async_rst_raw_cnt", raw_stall_cnt, 32'd0);
    check("async_rst_wb_cnt", wb_stall_cnt, 32'd0);
    check("async_rst_issue_cnt", issue_cnt, 32'd0);
`endif
    model_reset();
    drive(1'b0, 3, 0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic with occasional flushes and drain bursts.
    have      = 1'b0;
    drain_cnt = 0;
    p_unit = 0; p_rt = 0; p_rw = 1'b0; p_ra = 0; p_rb = 0; p_rc = 0; p_use = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        p_unit = $urandom_range(0, 3);
        p_rt   = $urandom_range(0, 7);
        p_rw   = ($urandom_range(0, 4) != 0);
        p_ra   = $urandom_range(0, 7);
        p_rb   = $urandom_range(0, 7);
        p_rc   = $urandom_range(0, 7);
        p_use  = $urandom_range(0, 7);
        have   = 1'b1;
      end
      drive(have, p_unit, p_rt, p_rw, p_ra, p_rb, p_rc, p_use);
      flush = ($urandom_range(0, 39) == 0);
      if (drain_cnt > 0) begin
        drain_req = 1'b1;
        drain_cnt--;
      end else begin
        drain_req = 1'b0;
        if ($urandom_range(0, 79) == 0) drain_cnt = $urandom_range(2, 12);
      end
      cycle();
      if (dut_acc) have = 1'b0;
    end
    flush     = 1'b0;
    drain_req = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
